// File: rtl/usb_rx_pkg.sv
// Shared USB receive types: line-state encoding, bit-timing constants and receiver states.
package usb_rx_pkg;

  // Low-speed line states as {D+, D-}
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_J   = 2'b01,
    LINE_K   = 2'b10,
    LINE_SE1 = 2'b11
  } d_port_t;

  localparam int BIT_PERIOD = 16;
  localparam int PHASE_W = $clog2(BIT_PERIOD);
  localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(7);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous multi-bit line state with a configurable reset value.
module sync2 #(
  parameter int W = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_rx.sv
// USB low-speed receiver: DPLL-style bit recovery, NRZI decode, SYNC detect,
// bit-unstuffing, byte assembly and EOP / error detection.
module usb_rx
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    d_i,
  output logic [7:0] data,
  output logic       valid,
  output logic       active,
  output logic       eop,
  output logic       error
);

  logic [1:0]         line_raw;
  d_port_t            line, line_q, prev_jk, prev_n;
  logic [PHASE_W-1:0] phase;
  logic               strobe, jk_change, nrzi_bit, is_jk;
  rx_state_t          state, state_n;
  logic [2:0]         zeros, zeros_n, ones, ones_n, bitcnt, bitcnt_n;
  logic [7:0]         shreg, shreg_n, data_n;
  logic               valid_n, eop_n, error_n, active_n;

  sync2 #(.W(2), .RST_VAL(LINE_J)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_i),
    .q     (line_raw)
  );

  assign line      = d_port_t'(line_raw);
  assign jk_change = ((line == LINE_J) && (line_q == LINE_K)) ||
                     ((line == LINE_K) && (line_q == LINE_J));
  assign strobe    = (phase == SAMPLE_PHASE);
  assign is_jk     = (line == LINE_J) || (line == LINE_K);
  assign nrzi_bit  = (line == prev_jk);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RESET;
      line_q  <= LINE_J;
      phase   <= '0;
      prev_jk <= LINE_J;
      zeros   <= '0;
      ones    <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
      eop     <= 1'b0;
      error   <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      line_q  <= line;
      // Only J<->K edges realign; SE0 lets the phase free-run so EOP stays bit-aligned
      phase   <= jk_change ? '0 : phase + 1'b1;
      prev_jk <= prev_n;
      zeros   <= zeros_n;
      ones    <= ones_n;
      bitcnt  <= bitcnt_n;
      shreg   <= shreg_n;
      data    <= data_n;
      valid   <= valid_n;
      eop     <= eop_n;
      error   <= error_n;
      active  <= active_n;
    end
  end

  always_comb begin
    state_n  = state;
    prev_n   = prev_jk;
    zeros_n  = zeros;
    ones_n   = ones;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    data_n   = data;
    valid_n  = 1'b0;
    eop_n    = 1'b0;
    error_n  = 1'b0;
    active_n = active;
    case (state)
      ST_RESET: state_n = ST_IDLE;
      ST_IDLE: begin
        prev_n = LINE_J;
        if (strobe && (line == LINE_K)) begin
          state_n = ST_SYNC;
          prev_n  = LINE_K;
          zeros_n = 3'd1;
        end
      end
      ST_SYNC: if (strobe) begin
        if (!is_jk) begin
          state_n = ST_IDLE;
        end else begin
          prev_n = line;
          if (!nrzi_bit) begin
            zeros_n = (zeros == 3'd7) ? zeros : zeros + 3'd1;
          end else if (zeros >= 3'd4) begin
            state_n  = ST_DATA;
            active_n = 1'b1;
            ones_n   = '0;
            bitcnt_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DATA: if (strobe) begin
        if ((line == LINE_SE1) || ((line == LINE_SE0) && (bitcnt != 3'd0))) begin
          state_n  = ST_ERROR;
          error_n  = 1'b1;
          active_n = 1'b0;
          zeros_n  = '0;
        end else if (line == LINE_SE0) begin
          state_n = ST_EOP;
        end else begin
          prev_n = line;
          // Six ones in a row: this bit is stuffing and must be a 0
          if (ones == 3'd6) begin
            ones_n = '0;
            if (nrzi_bit) begin
              state_n  = ST_ERROR;
              error_n  = 1'b1;
              active_n = 1'b0;
              zeros_n  = '0;
            end
          end else begin
            ones_n   = nrzi_bit ? ones + 3'd1 : 3'd0;
            shreg_n  = {nrzi_bit, shreg[7:1]};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              data_n  = shreg_n;
              valid_n = 1'b1;
            end
          end
        end
      end
      ST_EOP: if (strobe) begin
        if (line == LINE_J) begin
          state_n  = ST_IDLE;
          eop_n    = 1'b1;
          active_n = 1'b0;
        end else if (line != LINE_SE0) begin
          state_n  = ST_ERROR;
          error_n  = 1'b1;
          active_n = 1'b0;
          zeros_n  = '0;
        end
      end
      ST_ERROR: begin
        active_n = 1'b0;
        // zeros is reused here as the consecutive-J counter
        if (strobe) begin
          if (line != LINE_J) begin
            zeros_n = '0;
          end else if (zeros == 3'd1) begin
            state_n = ST_IDLE;
          end else begin
            zeros_n = 3'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_rx.sv
// Directed self-checking bench for usb_rx: a bench-side NRZI/bit-stuffing encoder drives
// the line and a monitor collects received bytes, eop and error pulses.
module tb_usb_rx;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  d_port_t    d_i;
  logic [7:0] data;
  logic       valid, active, eop, error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  int n_eop, n_err, overlap, act_bad;

  logic [1:0] syms[$];
  logic [7:0] tx_bytes[$];
  logic [1:0] last_jk;
  int ones_run;

  usb_rx dut (
    .clk    (clk),
    .reset  (reset),
    .d_i    (d_i),
    .data   (data),
    .valid  (valid),
    .active (active),
    .eop    (eop),
    .error  (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) begin
        rx_q.push_back(data);
        if (active !== 1'b1) act_bad++;
      end
      if (eop) n_eop++;
      if (error) n_err++;
      if ((int'(valid) + int'(eop) + int'(error)) > 1) overlap++;
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    n_eop = 0; n_err = 0; overlap = 0; act_bad = 0;
    syms.delete();
  endtask

  task automatic add_sym(input logic [1:0] s);
    syms.push_back(s);
    if (s == LINE_J || s == LINE_K) last_jk = s;
  endtask

  task automatic add_sync();
    last_jk = LINE_J;
    for (int i = 0; i < 3; i++) begin add_sym(LINE_K); add_sym(LINE_J); end
    add_sym(LINE_K); add_sym(LINE_K);
    ones_run = 0;
  endtask

  task automatic add_bit(input logic b);
    if (b) begin
      add_sym(last_jk);
      ones_run++;
      if (ones_run == 6) begin
        add_sym((last_jk == LINE_J) ? LINE_K : LINE_J);
        ones_run = 0;
      end
    end else begin
      add_sym((last_jk == LINE_J) ? LINE_K : LINE_J);
      ones_run = 0;
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) add_bit(b[i]);
  endtask

  task automatic add_eop_idle();
    add_sym(LINE_SE0); add_sym(LINE_SE0);
    for (int i = 0; i < 5; i++) add_sym(LINE_J);
  endtask

  task automatic drive_syms();
    foreach (syms[i]) begin
      d_i = d_port_t'(syms[i]);
      repeat (BIT_PERIOD) @(negedge clk);
    end
    syms.delete();
  endtask

  task automatic send_packet();
    add_sync();
    foreach (tx_bytes[i]) add_byte(tx_bytes[i]);
    add_eop_idle();
    drive_syms();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d_i = LINE_J;
    repeat (4) @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL reset_active: got %b want 0", active); end
    n_checks++; if (eop !== 1'b0) begin n_errors++; $display("FAIL reset_eop: got %b want 0", eop); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b want 0", error); end
    reset = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_single_byte();
    clear_mon();
    tx_bytes = '{8'hA5};
    send_packet();
    n_checks++; if (rx_q.size() != 1) begin n_errors++; $display("FAIL a5_count: got %0d want 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 8'hA5) begin n_errors++; $display("FAIL a5_data: got %h want a5", rx_q[0]); end
    end
    n_checks++; if (n_eop != 1) begin n_errors++; $display("FAIL a5_eop: got %0d want 1", n_eop); end
    n_checks++; if (n_err != 0) begin n_errors++; $display("FAIL a5_error: got %0d want 0", n_err); end
    n_checks++; if (act_bad != 0) begin n_errors++; $display("FAIL a5_active_at_valid: got %0d low want 0", act_bad); end
    n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL a5_active_end: got %b want 0", active); end
    n_checks++; if (data !== 8'hA5) begin n_errors++; $display("FAIL a5_data_hold: got %h want a5", data); end
  endtask

  task automatic test_stuffing();
    clear_mon();
    tx_bytes = '{8'hFF, 8'h3F};
    send_packet();
    n_checks++; if (rx_q.size() != 2) begin n_errors++; $display("FAIL stuff_count: got %0d want 2", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 8'hFF) begin n_errors++; $display("FAIL stuff_byte0: got %h want ff", rx_q[0]); end
      n_checks++; if (rx_q[1] !== 8'h3F) begin n_errors++; $display("FAIL stuff_byte1: got %h want 3f", rx_q[1]); end
    end
    n_checks++; if (n_eop != 1) begin n_errors++; $display("FAIL stuff_eop: got %0d want 1", n_eop); end
    n_checks++; if (n_err != 0) begin n_errors++; $display("FAIL stuff_error: got %0d want 0", n_err); end
  endtask

  task automatic test_stuff_error();
    clear_mon();
    add_sync();
    for (int i = 0; i < 7; i++) add_sym(last_jk);
    for (int i = 0; i < 6; i++) add_sym(LINE_J);
    drive_syms();
    n_checks++; if (n_err != 1) begin n_errors++; $display("FAIL stufferr_error: got %0d want 1", n_err); end
    n_checks++; if (rx_q.size() != 0) begin n_errors++; $display("FAIL stufferr_valid: got %0d want 0", rx_q.size()); end
    n_checks++; if (n_eop != 0) begin n_errors++; $display("FAIL stufferr_eop: got %0d want 0", n_eop); end
    n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL stufferr_active: got %b want 0", active); end
    clear_mon();
    tx_bytes = '{8'h81};
    send_packet();
    n_checks++; if (rx_q.size() != 1) begin n_errors++; $display("FAIL recover_count: got %0d want 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 8'h81) begin n_errors++; $display("FAIL recover_data: got %h want 81", rx_q[0]); end
    end
    n_checks++; if (n_eop != 1) begin n_errors++; $display("FAIL recover_eop: got %0d want 1", n_eop); end
  endtask

  task automatic test_se0_mid_byte();
    clear_mon();
    add_sync();
    for (int i = 0; i < 5; i++) add_bit(i[0]);
    add_eop_idle();
    for (int i = 0; i < 3; i++) add_sym(LINE_J);
    drive_syms();
    n_checks++; if (n_err != 1) begin n_errors++; $display("FAIL se0mid_error: got %0d want 1", n_err); end
    n_checks++; if (rx_q.size() != 0) begin n_errors++; $display("FAIL se0mid_valid: got %0d want 0", rx_q.size()); end
    n_checks++; if (n_eop != 0) begin n_errors++; $display("FAIL se0mid_eop: got %0d want 0", n_eop); end
  endtask

  task automatic test_loop_skew();
    for (int skew = 0; skew < 16; skew++) begin
      clear_mon();
      repeat (skew) @(negedge clk);
      tx_bytes = '{8'h00, 8'hFF, 8'h7E};
      send_packet();
      n_checks++; if (rx_q.size() != 3) begin n_errors++; $display("FAIL loop_count skew %0d: got %0d want 3", skew, rx_q.size()); end
      else begin
        n_checks++; if (rx_q[0] !== 8'h00) begin n_errors++; $display("FAIL loop_b0 skew %0d: got %h want 00", skew, rx_q[0]); end
        n_checks++; if (rx_q[1] !== 8'hFF) begin n_errors++; $display("FAIL loop_b1 skew %0d: got %h want ff", skew, rx_q[1]); end
        n_checks++; if (rx_q[2] !== 8'h7E) begin n_errors++; $display("FAIL loop_b2 skew %0d: got %h want 7e", skew, rx_q[2]); end
      end
      n_checks++; if (n_eop != 1) begin n_errors++; $display("FAIL loop_eop skew %0d: got %0d want 1", skew, n_eop); end
      n_checks++; if (n_err != 0) begin n_errors++; $display("FAIL loop_error skew %0d: got %0d want 0", skew, n_err); end
      n_checks++; if (overlap != 0) begin n_errors++; $display("FAIL loop_overlap skew %0d: got %0d want 0", skew, overlap); end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_mon();
    add_sync();
    for (int i = 0; i < 5; i++) add_bit(i < 2);
    drive_syms();
    n_checks++; if (active !== 1'b1) begin n_errors++; $display("FAIL midrst_active_before: got %b want 1", active); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (data !== 8'h00) begin n_errors++; $display("FAIL midrst_data: got %h want 00", data); end
    n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL midrst_active: got %b want 0", active); end
    n_checks++; if ({valid, eop, error} !== 3'b000) begin n_errors++; $display("FAIL midrst_pulses: got %b want 000", {valid, eop, error}); end
    @(negedge clk);
    reset = 1'b0;
    d_i = LINE_J;
    repeat (20 * BIT_PERIOD) @(negedge clk);
    n_checks++; if (n_err != 0 || n_eop != 0) begin n_errors++; $display("FAIL midrst_no_err_eop: got err %0d eop %0d want 0 0", n_err, n_eop); end
    clear_mon();
    tx_bytes = '{8'h5A};
    send_packet();
    n_checks++; if (rx_q.size() != 1) begin n_errors++; $display("FAIL after_rst_count: got %0d want 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 8'h5A) begin n_errors++; $display("FAIL after_rst_data: got %h want 5a", rx_q[0]); end
    end
    n_checks++; if (n_eop != 1) begin n_errors++; $display("FAIL after_rst_eop: got %0d want 1", n_eop); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_byte();
    test_stuffing();
    test_stuff_error();
    test_se0_mid_byte();
    test_loop_skew();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 The module SHALL have no parameters; bit period (16 clk) and sample phase (7) are fixed package constants.
REQ-002 clk  input  1  system clock, 24 MHz, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 d_i  input  2 (d_port_t)  USB low-speed line state D+,D- (SE0/J/K/SE1), asynchronous to clk.
REQ-005 data  output  8  received byte, LSB = first bit on wire.
REQ-006 valid  output  1  one-cycle pulse: data holds a new byte.
REQ-007 active  output  1  high from SYNC completion until EOP or error.
REQ-008 eop  output  1  one-cycle pulse on valid end-of-packet.
REQ-009 error  output  1  one-cycle pulse on stuff error, SE1, or SE0 at non-byte boundary.

Function
REQ-010 d_i SHALL pass through a two-flop synchronizer; all logic below uses the synchronized value (line).
REQ-011 A 4-bit phase counter SHALL reset to 0 on every J<->K change of line and otherwise increment, wrapping 15->0.
REQ-012 A sample strobe SHALL occur when phase counter == 7; no other cycle samples line.
REQ-013 NRZI decode at each strobe: bit = 1 if sampled J/K equals the previous sampled J/K, else 0; previous value is J in IDLE.
REQ-014 States: RESET, IDLE, SYNC, DATA, EOP, ERROR; RESET -> IDLE when reset low.
REQ-015 IDLE -> SYNC on first strobe sampling K.
REQ-016 SYNC: count consecutive decoded 0 bits (initial K counts as one); decoded 1 after >=4 zeros -> DATA, active rises next cycle; decoded 1 after <4 zeros, or SE0/SE1 -> IDLE, no error.
REQ-017 DATA: a ones counter counts consecutive decoded 1s, cleared on 0; bit following six 1s is a stuff bit: discarded if 0, error + ERROR if 1.
REQ-018 DATA: non-stuff bits SHALL shift into an 8-bit register LSB first; 3-bit bit counter wraps 7->0.
REQ-019 On the 8th non-stuff bit, data SHALL load the completed byte and valid SHALL pulse on the cycle after that strobe.
REQ-020 data SHALL hold its value until the next valid; it is not cleared at EOP.
REQ-021 DATA: SE0 at strobe -> EOP if bit counter == 0, else error + ERROR; SE1 at strobe -> error + ERROR.
REQ-022 EOP: first strobe sampling J -> eop pulse, active low, IDLE; K or SE1 at strobe -> error + ERROR; SE0 remains in EOP.
REQ-023 ERROR: active low; return to IDLE after two consecutive strobes sampling J.
REQ-024 Phase counter continues free-running during SE0 (no J/K change) so EOP strobes stay bit-aligned.
REQ-025 valid, eop, error SHALL never be asserted in the same cycle; a byte completed on the strobe before SE0 still produces valid.

Reset
REQ-026 On reset: state RESET, data 8'h00, valid/active/eop/error 0, phase/bit/ones counters 0, synchronizer flops J.
REQ-027 Reset mid-packet SHALL abort without error or eop; outputs are 0 from the cycle after reset is sampled.

Structure
REQ-028 d_port_t (SE0,J,K,SE1) SHALL come from the shared package types; constants BIT_PERIOD=16 and SAMPLE_PHASE=7 SHALL be added there.
REQ-029 The two-flop synchronizer SHALL be sub-module sync2 (1 instance, 2 bits wide); all else is in usb_rx.

Verification
REQ-030 SYNC KJKJKJKK, byte 8'hA5, SE0 x2 bits, J -> one valid with data=8'hA5, active high through byte, one eop, no error.
REQ-031 SYNC, byte 8'hFF (stuff 0 after six 1s), 8'h3F -> valid data=8'hFF then 8'h3F, stuff bits discarded, eop.
REQ-032 SYNC, seven consecutive 1s without stuff bit -> error pulse, active low, no valid, recovery to IDLE after 2 J bits.
REQ-033 SYNC, 5 data bits, SE0 -> error pulse, no valid, no eop.
REQ-034 Transmitter-to-receiver loop with usb_tx, bytes 8'h00,8'hFF,8'h7E and clk phase skew 0..15 -> identical bytes received, eop.
REQ-035 reset pulse mid-byte of 8'hC3 -> all outputs 0 next cycle, no error/eop; subsequent packet 8'h5A received correctly.
